// File: rtl/vote_pkg.sv
// Shared definitions for the voting session controller: state encoding,
// voter population sizes and the voter-index-to-weight mapping.
package vote_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OPEN  = 2'd1,
      ST_TALLY = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int W_NP     = 1;
   localparam int W_VIP    = 4;
   localparam int W_VVIP   = 16;
   localparam int N_NP     = 32;
   localparam int N_VIP    = 8;
   localparam int N_VOTERS = 41;

   localparam logic [5:0] LAST_IDX = 6'(N_VOTERS - 1);

   // Voters 0..31 are normal, 32..39 VIP, 40 is the single VVIP.
   function automatic logic [7:0] voter_weight(input logic [5:0] idx);
      logic [7:0] w;
      if (idx < 6'(N_NP)) begin
         w = 8'(W_NP);
      end else if (idx < 6'(N_NP + N_VIP)) begin
         w = 8'(W_VIP);
      end else begin
         w = 8'(W_VVIP);
      end
      return w;
   endfunction

endpackage

// File: rtl/vote_tally_seq.sv
// Serial weighted accumulator: walks one voter per cycle while go is high and
// presents the final sum (with sum_valid) during the last voter's cycle.
module vote_tally_seq
   import vote_pkg::*;
(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                go,
   input  logic [N_VOTERS-1:0] ballots,
   output logic [7:0]          sum,
   output logic                sum_valid
);

   logic [5:0] idx_r;
   logic [7:0] acc_r;
   logic [7:0] add_s;

   // Weight contributed by the voter currently under the index.
   always_comb begin
      add_s = 8'd0;
      if (ballots[idx_r]) begin
         add_s = voter_weight(idx_r);
      end else begin
         add_s = 8'd0;
      end
   end

   assign sum       = acc_r + add_s;
   assign sum_valid = go && (idx_r == LAST_IDX);

   // Index/accumulator advance; both rest at zero whenever go is low.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_r <= 6'd0;
         acc_r <= 8'd0;
      end else if (go) begin
         if (idx_r == LAST_IDX) begin
            idx_r <= 6'd0;
            acc_r <= 8'd0;
         end else begin
            idx_r <= idx_r + 6'd1;
            acc_r <= sum;
         end
      end else begin
         idx_r <= 6'd0;
         acc_r <= 8'd0;
      end
   end

endmodule

// File: rtl/vote_session_ctrl.sv
// Voting session controller: opens a time-bounded ballot window, latches sticky
// votes, hands the frozen ballots to the serial tally and holds the result until ack.
module vote_session_ctrl
   import vote_pkg::*;
#(
   parameter int TIMEOUT   = 100,
   parameter int THRESHOLD = 41
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        close,
   input  logic [31:0] np,
   input  logic [7:0]  vip,
   input  logic        vvip,
   input  logic        ack,
   output logic        ballot_open,
   output logic        busy,
   output logic        done,
   output logic [7:0]  result,
   output logic        pass
);

   localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);
   localparam logic [7:0]  THRESH_8   = 8'(THRESHOLD);

   state_t      state_r;
   logic [31:0] st_np_r;
   logic [7:0]  st_vip_r;
   logic        st_vvip_r;
   logic [15:0] timer_r;
   logic [7:0]  result_r;
   logic        pass_r;

   logic        tally_go_s;
   logic [7:0]  tally_sum_s;
   logic        tally_last_s;

   assign tally_go_s = (state_r == ST_TALLY);

   vote_tally_seq u_tally (
      .clk       (clk),
      .reset_n   (reset_n),
      .go        (tally_go_s),
      .ballots   ({st_vvip_r, st_vip_r, st_np_r}),
      .sum       (tally_sum_s),
      .sum_valid (tally_last_s)
   );

   // Session FSM with ballot latching, window timer and result capture.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= ST_IDLE;
         st_np_r   <= 32'd0;
         st_vip_r  <= 8'd0;
         st_vvip_r <= 1'b0;
         timer_r   <= 16'd0;
         result_r  <= 8'd0;
         pass_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  state_r   <= ST_OPEN;
                  st_np_r   <= 32'd0;
                  st_vip_r  <= 8'd0;
                  st_vvip_r <= 1'b0;
                  timer_r   <= 16'd0;
                  result_r  <= 8'd0;
                  pass_r    <= 1'b0;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_OPEN: begin
               st_np_r   <= st_np_r | np;
               st_vip_r  <= st_vip_r | vip;
               st_vvip_r <= st_vvip_r | vvip;
               timer_r   <= timer_r + 16'd1;
               if (close || (timer_r == TIMER_LAST)) begin
                  state_r <= ST_TALLY;
               end else begin
                  state_r <= ST_OPEN;
               end
            end
            ST_TALLY: begin
               if (tally_last_s) begin
                  result_r <= tally_sum_s;
                  pass_r   <= (tally_sum_s >= THRESH_8);
                  state_r  <= ST_DONE;
               end else begin
                  state_r <= ST_TALLY;
               end
            end
            ST_DONE: begin
               if (ack) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_DONE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   assign ballot_open = (state_r == ST_OPEN);
   assign busy        = (state_r == ST_OPEN) || (state_r == ST_TALLY);
   assign done        = (state_r == ST_DONE);
   assign result      = result_r;
   assign pass        = pass_r;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Randomized self-checking bench for vote_session_ctrl against a per-session
// behavioural model (OR-accumulated ballots scored by population counts).
module tb_vote_session_ctrl;

   localparam int TIMEOUT   = 100;
   localparam int THRESHOLD = 41;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        close;
   logic [31:0] np;
   logic [7:0]  vip;
   logic        vvip;
   logic        ack;
   logic        ballot_open;
   logic        busy;
   logic        done;
   logic [7:0]  result;
   logic        pass;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] q_np[$];
   logic [7:0]  q_vip[$];
   logic        q_vvip[$];
   int          close_at;

   vote_session_ctrl #(.TIMEOUT(TIMEOUT), .THRESHOLD(THRESHOLD)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .close       (close),
      .np          (np),
      .vip         (vip),
      .vvip        (vvip),
      .ack         (ack),
      .ballot_open (ballot_open),
      .busy        (busy),
      .done        (done),
      .result      (result),
      .pass        (pass)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic junk();
      np   = $urandom;
      vip  = 8'($urandom);
      vvip = 1'($urandom);
   endtask

   function automatic int score(input logic [31:0] a, input logic [7:0] b, input logic c);
      return $countones(a) + 4 * $countones(b) + (c ? 16 : 0);
   endfunction

   task automatic clear_plan();
      q_np.delete();
      q_vip.delete();
      q_vvip.delete();
      close_at = 0;
   endtask

   // One full session: IDLE -> OPEN (planned votes) -> TALLY -> DONE -> ack -> IDLE.
   task automatic run_session(input string name, input bit ack_with_start);
      logic [31:0] m_np;
      logic [7:0]  m_vip;
      logic        m_vvip;
      int          c;
      int          n;
      bit          last;
      int          exp_s;
      logic [7:0]  held;
      m_np = 32'd0; m_vip = 8'd0; m_vvip = 1'b0;
      junk(); start = 1'b1; close = 1'b1; ack = 1'b0;
      step();
      check_val({name, ".entry_open"}, 32'(ballot_open), 32'd1);
      check_val({name, ".entry_result"}, 32'(result), 32'd0);
      c = 0; last = 1'b0;
      while (!last) begin
         c++;
         check_val({name, ".open"}, 32'(ballot_open), 32'd1);
         np   = (c <= q_np.size())   ? q_np[c-1]   : 32'd0;
         vip  = (c <= q_vip.size())  ? q_vip[c-1]  : 8'd0;
         vvip = (c <= q_vvip.size()) ? q_vvip[c-1] : 1'b0;
         start = 1'($urandom);
         ack   = 1'($urandom);
         close = (c == close_at);
         m_np = m_np | np; m_vip = m_vip | vip; m_vvip = m_vvip | vvip;
         last = (c == close_at) || (c == TIMEOUT);
         step();
      end
      check_val({name, ".closed"}, 32'(ballot_open), 32'd0);
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         check_val({name, ".tally_busy"}, 32'(busy), 32'd1);
         junk();
         start = 1'($urandom); close = 1'($urandom); ack = 1'($urandom);
         step();
         n++;
      end
      check_val({name, ".tally_len"}, 32'(n), 32'd41);
      exp_s = score(m_np, m_vip, m_vvip);
      check_val({name, ".result"}, 32'(result), 32'(exp_s));
      check_val({name, ".pass"}, 32'(pass), (exp_s >= THRESHOLD) ? 32'd1 : 32'd0);
      check_val({name, ".done_busy"}, 32'(busy), 32'd0);
      held = 8'(exp_s);
      for (int i = 0; i < 3; i++) begin
         junk(); start = 1'b1; close = 1'($urandom); ack = 1'b0;
         step();
         check_val({name, ".done_hold"}, 32'(done), 32'd1);
         check_val({name, ".result_hold"}, 32'(result), 32'(held));
      end
      junk(); ack = 1'b1; start = ack_with_start; close = 1'b0;
      step();
      start = 1'b0;
      check_val({name, ".ack_done"}, 32'(done), 32'd0);
      check_val({name, ".ack_open"}, 32'(ballot_open), 32'd0);
      check_val({name, ".ack_busy"}, 32'(busy), 32'd0);
      check_val({name, ".idle_result"}, 32'(result), 32'(held));
      junk(); ack = 1'b1; close = 1'b1;
      step();
      check_val({name, ".idle_stays"}, 32'(ballot_open | done), 32'd0);
      ack = 1'b0; close = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; close = 1'b0; ack = 1'b0;
      np = 32'd0; vip = 8'd0; vvip = 1'b0;
      #12;
      check_val("reset_outputs", {27'd0, ballot_open, busy, done, pass, 1'b0}, 32'd0);
      check_val("reset_result", 32'(result), 32'd0);
      reset_n = 1'b1;
      step();

      clear_plan();
      q_np = '{32'hFFFF_FFFF, 32'd0, 32'd0};
      close_at = 3;
      run_session("t1_np_only", 1'b0);

      clear_plan();
      q_np = '{32'hFFFF_FFFF}; q_vip = '{8'hFF}; q_vvip = '{1'b1};
      close_at = 2;
      run_session("t2_full", 1'b1);

      clear_plan();
      q_np   = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd1};
      q_vip  = '{8'd0, 8'h08, 8'd0, 8'd0, 8'd0};
      q_vvip = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      close_at = 5;
      run_session("t3_sticky", 1'b0);

      clear_plan();
      for (int i = 0; i < TIMEOUT; i++) q_vvip.push_back(i == TIMEOUT - 1);
      run_session("t4_timeout", 1'b0);

      // Reset pulsed in the middle of the tally.
      start = 1'b1; np = 32'hFFFF_FFFF; vip = 8'hFF; vvip = 1'b1;
      step();
      start = 1'b0; close = 1'b1;
      step();
      close = 1'b0;
      for (int i = 0; i < 10; i++) step();
      check_val("t5_pre_busy", 32'(busy), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check_val("t5_rst_flags", {29'd0, ballot_open, busy, done}, 32'd0);
      check_val("t5_rst_result", {23'd0, pass, result}, 32'd0);
      step();
      reset_n = 1'b1;
      step();
      check_val("t5_idle", {29'd0, ballot_open, busy, done}, 32'd0);
      clear_plan();
      close_at = 2;
      run_session("t5_empty", 1'b0);

      for (int s = 0; s < 8; s++) begin
         clear_plan();
         for (int i = 0; i < 110; i++) begin
            q_np.push_back($urandom & $urandom & $urandom & $urandom);
            q_vip.push_back(8'($urandom & $urandom & $urandom));
            q_vvip.push_back($urandom_range(0, 39) == 0);
         end
         close_at = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 110);
         run_session($sformatf("rnd%0d", s), 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vote_session_ctrl.md
Name: vote_session_ctrl

Overview:
Sequences one complete voting session end to end: it opens a ballot window, collects sticky votes from 32 normal voters, 8 VIP voters and 1 VVIP voter, closes the window on command or timeout, and then performs a serial weighted tally. It reports the weighted result and a pass flag, and holds them until the consumer acknowledges. It sits between the session-level control (start/close/ack) and the per-voter vote inputs, and replaces a free-running combinational counter with a controlled, time-bounded session.

Parameters:
TIMEOUT, 100, maximum OPEN cycles before auto-close (legal range 1..65535)
THRESHOLD, 41, weighted score at or above which pass=1 (8-bit compare)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous, active-low reset
start  input  1  begin a session; honoured only in IDLE
close  input  1  end the ballot window; honoured only in OPEN
np  input  32  normal voter votes, weight 1 each
vip  input  8  VIP voter votes, weight 4 each
vvip  input  1  VVIP voter vote, weight 16
ack  input  1  consumer has read the result; honoured only in DONE
ballot_open  output  1  high while in OPEN
busy  output  1  high in OPEN or TALLY
done  output  1  high in DONE
result  output  8  final weighted tally, valid while done=1
pass  output  1  (result >= THRESHOLD), valid while done=1

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE; ballots, timer, tally index, accumulator, result and pass all 0. All outputs read 0. Reset in any state aborts the session with no residue.
- States, 2-bit: IDLE=0, OPEN=1, TALLY=2, DONE=3.
- IDLE: vote inputs are ignored. If start=1: go to OPEN next cycle; clear ballots, timer, result and pass.
- OPEN:
  - Every cycle: st_np|=np, st_vip|=vip, st_vvip|=vvip. Votes are sticky; repeat votes have no extra effect.
  - timer increments each cycle.
  - If close=1 or timer==TIMEOUT-1: go to TALLY next cycle. Votes present in that final OPEN cycle are included.
  - start is ignored in OPEN.
- TALLY:
  - Ballots are frozen; vote inputs are ignored.
  - idx runs 0..40, one voter per cycle. Voters 0..31 are np bits (weight 1), 32..39 are vip bits (weight 4), 40 is vvip (weight 16).
  - acc += weight when the voter's ballot bit is 1.
  - On idx==40: register result=final acc and pass=(final acc>=THRESHOLD), then go to DONE.
  - TALLY lasts exactly 41 cycles; done rises on the 42nd cycle after leaving OPEN.
  - start, close and ack are ignored in TALLY.
- DONE:
  - done=1; result and pass held stable.
  - ack=1: go to IDLE next cycle. result and pass keep their values until the next accepted start.
  - start is ignored in DONE; a new session requires ack first.
- Width: the maximum score is 32+32+16=80, so the 8-bit accumulator cannot overflow.
- THRESHOLD boundaries: THRESHOLD=0 gives pass=1 always; THRESHOLD>80 gives pass=0 always.
- Timer is 16 bits. With TIMEOUT=1, OPEN lasts exactly one cycle.
- All outputs are registered or decoded directly from state; no combinational path from inputs to outputs.

Decomposition:
- Package vote_pkg: state encoding constants, W_NP=1, W_VIP=4, W_VVIP=16, N_NP=32, N_VIP=8, N_VOTERS=41, and the voter-index-to-weight function.
- Sub-module vote_tally_seq: serial weighted accumulator.
  - Inputs: clk, reset_n, go, ballots[40:0].
  - Outputs: sum[7:0], sum_valid.
  - The controller FSM and timer remain in the top level.

Test Plan:
1. Reset, start; in OPEN cycle 1 np=32'hFFFFFFFF; close in cycle 3 -> TALLY for 41 cycles, then done=1, result=32, pass=0; ack -> IDLE.
2. Full vote: np=all ones, vip=8'hFF, vvip=1 in one OPEN cycle, then close -> result=80, pass=1.
3. Sticky votes: np[0] only in cycle 1, vip[3] only in cycle 2, vvip only in cycle 4, then close -> result=21, pass=0. Repeating np[0] in later cycles leaves the result at 21.
4. Timeout with TIMEOUT=100, close never asserted -> exactly 100 OPEN cycles. A vvip vote in OPEN cycle 100 counts (result=16). An np vote in the first TALLY cycle is ignored.
5. reset_n pulsed low mid-TALLY -> all outputs 0 immediately, state IDLE. A new session with no votes yields result=0, pass=0.
6. Ignored inputs: votes in IDLE/DONE are not counted; start in OPEN/TALLY/DONE has no effect; ack in IDLE has no effect; start and ack together in DONE -> IDLE, not OPEN.
